preamble_seq_gen: RTL and testbench
===================================

Name: preamble_seq_gen

Overview:
- Parametrised 802.11a/g legacy preamble sequencer. Streams the full L-STF followed by the full L-LTF as I/Q samples at 20 MS/s.
- Successor to the fixed 16-sample short-preamble table. Adds:
  - a configurable short-symbol repeat count,
  - the long preamble with its GI2,
  - output width scaling,
  - valid/ready backpressure, start, abort and done control.
- Sits at the head of the TX chain, ahead of the symbol mux that switches to SIGNAL/DATA.

Parameters:
- DATA_W, 16, output sample width per rail (8..24); ROM words are 16-bit two's complement.
- N_STS, 10, number of 16-sample short symbols emitted (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a preamble; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream ready
- m_i  out  DATA_W  in-phase sample
- m_q  out  DATA_W  quadrature sample
- m_last  out  1  high with the final preamble sample
- busy  out  1  high from the start accept until done
- done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset is asynchronous and active-low (rst_n). Clocking is single-clock (clk).
- Reset values: m_valid=0, m_i=0, m_q=0, m_last=0, busy=0, done=0, state=IDLE, counters=0.
- States: IDLE -> SHORT -> LONG_GI -> LONG -> IDLE.
- IDLE:
  - start=1 loads short sample 0 into the output registers.
  - m_valid=1 and busy=1 on the next edge, giving 1-cycle latency from start to the first valid sample.
- A sample advances only on m_valid && m_ready. With m_valid=1 and m_ready=0, m_i, m_q and m_last are held bit-stable.
- SHORT:
  - Short ROM addr = cnt[3:0].
  - Lasts N_STS*16 accepted samples, then enters LONG_GI.
  - I rail: 05E3 EF0C FE47 1246 0BC7 1246 FE47 EF0C 05E3 004D F5F3 FE61 0000 FE61 F5F3 004D.
  - Q rail: the I-rail table rotated by 8 entries (Q[k] = I[(k+8) mod 16]).
- LONG_GI: 32 samples, long ROM addr 32..63.
- LONG: 128 samples, long ROM addr 0..63 played twice.
- m_last=1 on LONG sample 127. Total length is N_STS*16+160 samples (320 at default).
- Acceptance of the last sample:
  - next edge: m_valid=0, m_last=0, busy=0, done=1 for exactly one cycle, state=IDLE.
  - start is ignored on the cycle done is high.
- start while busy is ignored, with no restart.
- abort is evaluated before the handshake and wins over it, including when abort and the final accept coincide. On the next edge: state=IDLE, m_valid=0, busy=0, m_last=0, no done pulse. Output data is cleared to 0.
- Width rule (both rails):
  - DATA_W >= 16: ROM word left-aligned, LSBs zero-filled (value << (DATA_W-16)).
  - DATA_W < 16: top DATA_W bits kept (arithmetic truncation, no rounding).
- Long ROM is combinational; all outputs are registered.

Optional Feature:
- Macro PREAMBLE_WINDOW_EN.
- Defined: 802.11 boundary windowing. The first SHORT sample and the first LONG_GI sample are each arithmetic-shifted right by 1 before width scaling (for example, 05E3 -> 02F1). All other samples are unchanged.
- Undefined: every sample is emitted at full table amplitude.
- Sequence length and timing are identical in both builds.

Decomposition:
- Package preamble_pkg holds:
  - the state enum,
  - SHORT_LEN=16, GI2_LEN=32, LONG_LEN=64,
  - the 16-entry short I table (Q derived by rotation),
  - the 64-entry long I/Q tables (IEEE 802.11a L-LTF time domain, same Q-format as the short table).
- One sub-module, long_preamble_rom: 6-bit addr to 16-bit dout_i/dout_q, combinational, reading from the package tables.
- The short table is indexed inline.

Test Plan:
- Reset: assert rst_n=0 mid-SHORT -> all outputs 0 asynchronously, state IDLE. After release, no m_valid until start.
- Defaults, m_ready=1, start pulse:
  - m_valid one cycle later.
  - Sample 0 I=05E3 Q=05E3; sample 1 I=EF0C Q=004D; sample 16 equals sample 0.
  - Sample 160 equals long addr 32.
  - Exactly 320 accepts, m_last only on #320, done one cycle after, busy low.
- Random m_ready (50%) -> data stable while stalled, sequence identical to the no-stall run, still 320 samples.
- abort asserted at accepted sample 200 -> m_valid=0 next cycle, no done pulse. A following start replays from sample 0.
- Parameter runs:
  - N_STS=2 -> 192 samples, LONG_GI starts at sample 32.
  - DATA_W=12 -> sample 0 I=05E; DATA_W=20 -> 05E30.
  - start during busy has no effect on the sequence.
- With PREAMBLE_WINDOW_EN defined -> sample 0 I=Q=02F1, sample 160 equals halved long addr 32, sample 1 unchanged (EF0C).

Source files
------------

// File: rtl/preamble_pkg.sv
// Shared types and tables for the 802.11a/g legacy preamble sequencer.
// Short and long tables are 16-bit two's complement samples in the same Q1.15 scaling.
package preamble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHORT   = 2'd1,
        ST_LONG_GI = 2'd2,
        ST_LONG    = 2'd3
    } state_e;

    localparam int SHORT_LEN = 32'sd16;
    localparam int GI2_LEN   = 32'sd32;
    localparam int LONG_LEN  = 32'sd64;

    // L-STF I rail; the Q rail is the same table rotated by half a period.
    localparam logic [15:0] SHORT_I [SHORT_LEN] = '{
        16'h05E3, 16'hEF0C, 16'hFE47, 16'h1246, 16'h0BC7, 16'h1246, 16'hFE47, 16'hEF0C,
        16'h05E3, 16'h004D, 16'hF5F3, 16'hFE61, 16'h0000, 16'hFE61, 16'hF5F3, 16'h004D
    };

    // L-LTF time-domain symbol x[0..63] in thousandths of full scale.
    localparam int LONG_I_MILLI [LONG_LEN] = '{
         32'sd156,  -32'sd5,    32'sd40,   32'sd97,   32'sd21,   32'sd60,  -32'sd115, -32'sd38,
         32'sd98,   32'sd53,    32'sd1,   -32'sd137,  32'sd24,   32'sd59,  -32'sd22,   32'sd119,
         32'sd62,   32'sd37,   -32'sd57,  -32'sd131,  32'sd82,   32'sd70,  -32'sd60,  -32'sd56,
        -32'sd35,  -32'sd122,  -32'sd127,  32'sd75,  -32'sd3,   -32'sd92,   32'sd92,   32'sd12,
        -32'sd156,  32'sd12,    32'sd92,  -32'sd92,  -32'sd3,    32'sd75,  -32'sd127, -32'sd122,
        -32'sd35,  -32'sd56,   -32'sd60,   32'sd70,   32'sd82,  -32'sd131, -32'sd57,   32'sd37,
         32'sd62,   32'sd119,  -32'sd22,   32'sd59,   32'sd24,  -32'sd137,  32'sd1,    32'sd53,
         32'sd98,  -32'sd38,   -32'sd115,  32'sd60,   32'sd21,   32'sd97,   32'sd40,  -32'sd5
    };

    localparam int LONG_Q_MILLI [LONG_LEN] = '{
         32'sd0,   -32'sd120,  -32'sd111,  32'sd83,   32'sd28,  -32'sd88,  -32'sd55,  -32'sd106,
        -32'sd26,   32'sd4,    -32'sd115, -32'sd47,  -32'sd59,  -32'sd15,   32'sd161, -32'sd4,
        -32'sd62,   32'sd98,    32'sd39,   32'sd65,   32'sd92,   32'sd14,   32'sd81,  -32'sd22,
        -32'sd151, -32'sd17,   -32'sd21,  -32'sd74,   32'sd54,   32'sd115,  32'sd106,  32'sd98,
         32'sd0,   -32'sd98,   -32'sd106, -32'sd115, -32'sd54,   32'sd74,   32'sd21,   32'sd17,
         32'sd151,  32'sd22,   -32'sd81,  -32'sd14,  -32'sd92,  -32'sd65,  -32'sd39,  -32'sd98,
         32'sd62,   32'sd4,    -32'sd161,  32'sd15,   32'sd59,   32'sd47,   32'sd115, -32'sd4,
         32'sd26,   32'sd106,   32'sd55,   32'sd88,  -32'sd28,  -32'sd83,   32'sd111,  32'sd120
    };

    // Thousandths to Q1.15 word, rounding half away from zero.
    function automatic logic [15:0] milli_to_q15(input int milli);
        int prod;
        int word;
        prod = milli * 32'sd32768;
        if (prod >= 32'sd0) begin
            word = (prod + 32'sd500) / 32'sd1000;
        end else begin
            word = -((32'sd500 - prod) / 32'sd1000);
        end
        return word[15:0];
    endfunction

endpackage

// File: rtl/long_preamble_rom.sv
// Combinational L-LTF ROM: 6-bit sample address to 16-bit I/Q words.
module long_preamble_rom
    import preamble_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [15:0] dout_i,
    output logic [15:0] dout_q
);

    logic [15:0] rom_i [LONG_LEN];
    logic [15:0] rom_q [LONG_LEN];

    for (genvar k = 0; k < LONG_LEN; k++) begin : g_rom
        assign rom_i[k] = milli_to_q15(LONG_I_MILLI[k]);
        assign rom_q[k] = milli_to_q15(LONG_Q_MILLI[k]);
    end

    // Table read.
    always_comb begin
        dout_i = rom_i[addr];
        dout_q = rom_q[addr];
    end

endmodule

// File: rtl/preamble_seq_gen.sv
// 802.11a/g legacy preamble sequencer: N_STS short symbols, GI2, two long symbols, valid/ready out.
// Define PREAMBLE_WINDOW_EN to halve the first STF sample and the first GI2 sample.
module preamble_seq_gen
    import preamble_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_STS  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_i,
    output logic [DATA_W-1:0] m_q,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] SHORT_LAST = 8'(N_STS * SHORT_LEN - 32'sd1);
    localparam logic [7:0] GI_LAST    = 8'(GI2_LEN - 32'sd1);
    localparam logic [7:0] LONG_LAST  = 8'(32'sd2 * LONG_LEN - 32'sd1);

    state_e      state_r;
    state_e      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic        accept_s;
    logic        valid_s;
    logic        last_s;
    logic        busy_s;
    logic        done_s;
    logic        load_s;
    logic        clear_s;
    logic [3:0]  short_q_idx_s;
    logic [5:0]  long_addr_s;
    logic [15:0] long_i_s;
    logic [15:0] long_q_s;
    logic [15:0] sel_i_s;
    logic [15:0] sel_q_s;
    logic [15:0] raw_i_s;
    logic [15:0] raw_q_s;

    // Left-align a 16-bit word into DATA_W bits: zero-fill when wider, keep the MSBs when narrower.
    function automatic logic [DATA_W-1:0] scale(input logic [15:0] word);
        logic [DATA_W+15:0] ext;
        ext = {word, {DATA_W{1'b0}}};
        return ext[DATA_W+15 -: DATA_W];
    endfunction

    assign accept_s = m_valid & m_ready;

    // Next state, counter and control; abort takes priority over any handshake.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        valid_s = m_valid;
        last_s  = m_last;
        busy_s  = busy;
        done_s  = 1'b0;
        load_s  = 1'b0;
        clear_s = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            valid_s = 1'b0;
            last_s  = 1'b0;
            busy_s  = 1'b0;
            clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !done) begin
                        state_s = ST_SHORT;
                        cnt_s   = 8'd0;
                        valid_s = 1'b1;
                        busy_s  = 1'b1;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHORT: begin
                    if (accept_s) begin
                        load_s = 1'b1;
                        if (cnt_r == SHORT_LAST) begin
                            state_s = ST_LONG_GI;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_LONG_GI: begin
                    if (accept_s) begin
                        load_s = 1'b1;
                        if (cnt_r == GI_LAST) begin
                            state_s = ST_LONG;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_LONG: begin
                    if (accept_s) begin
                        if (cnt_r == LONG_LAST) begin
                            state_s = ST_IDLE;
                            cnt_s   = 8'd0;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                            clear_s = 1'b1;
                        end else begin
                            cnt_s  = cnt_r + 8'd1;
                            last_s = (cnt_r == (LONG_LAST - 8'd1));
                            load_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // The sample fetched is the one at the next position, so it lands in the output register with it.
    assign short_q_idx_s = cnt_s[3:0] + 4'd8;
    assign long_addr_s   = (state_s == ST_LONG_GI) ? {1'b1, cnt_s[4:0]} : cnt_s[5:0];

    long_preamble_rom u_long_rom (
        .addr   (long_addr_s),
        .dout_i (long_i_s),
        .dout_q (long_q_s)
    );

    // Sample source selection by phase.
    always_comb begin
        sel_i_s = 16'h0000;
        sel_q_s = 16'h0000;
        case (state_s)
            ST_SHORT: begin
                sel_i_s = SHORT_I[cnt_s[3:0]];
                sel_q_s = SHORT_I[short_q_idx_s];
            end
            ST_LONG_GI, ST_LONG: begin
                sel_i_s = long_i_s;
                sel_q_s = long_q_s;
            end
            default: begin
                sel_i_s = 16'h0000;
                sel_q_s = 16'h0000;
            end
        endcase
    end

`ifdef PREAMBLE_WINDOW_EN
    // Half amplitude on the first sample of the STF and of GI2.
    always_comb begin
        if (((state_s == ST_SHORT) || (state_s == ST_LONG_GI)) && (cnt_s == 8'd0)) begin
            raw_i_s = {sel_i_s[15], sel_i_s[15:1]};
            raw_q_s = {sel_q_s[15], sel_q_s[15:1]};
        end else begin
            raw_i_s = sel_i_s;
            raw_q_s = sel_q_s;
        end
    end
`else
    // Full table amplitude on every sample.
    always_comb begin
        raw_i_s = sel_i_s;
        raw_q_s = sel_q_s;
    end
`endif

    // State, counters and registered outputs; data holds bit-stable unless loaded or cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_i     <= {DATA_W{1'b0}};
            m_q     <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            m_valid <= valid_s;
            m_last  <= last_s;
            busy    <= busy_s;
            done    <= done_s;
            if (clear_s) begin
                m_i <= {DATA_W{1'b0}};
                m_q <= {DATA_W{1'b0}};
            end else if (load_s) begin
                m_i <= scale(raw_i_s);
                m_q <= scale(raw_q_s);
            end else begin
                m_i <= m_i;
                m_q <= m_q;
            end
        end
    end

endmodule

// File: tb/tb_preamble_seq_gen.sv
// Randomised bench for preamble_seq_gen: three configurations checked against a sample-index model.
module tb_preamble_seq_gen;

    localparam int NS [3] = '{10, 2, 1};
    localparam int DW [3] = '{16, 12, 20};

    localparam logic [15:0] SH [16] = '{
        16'h05E3, 16'hEF0C, 16'hFE47, 16'h1246, 16'h0BC7, 16'h1246, 16'hFE47, 16'hEF0C,
        16'h05E3, 16'h004D, 16'hF5F3, 16'hFE61, 16'h0000, 16'hFE61, 16'hF5F3, 16'h004D
    };
    localparam int LI [64] = '{
         156,  -5,   40,   97,   21,   60, -115,  -38,   98,   53,    1, -137,   24,   59,  -22,  119,
          62,  37,  -57, -131,   82,   70,  -60,  -56,  -35, -122, -127,   75,   -3,  -92,   92,   12,
        -156,  12,   92,  -92,   -3,   75, -127, -122,  -35,  -56,  -60,   70,   82, -131,  -57,   37,
          62, 119,  -22,   59,   24, -137,    1,   53,   98,  -38, -115,   60,   21,   97,   40,   -5
    };
    localparam int LQ [64] = '{
           0, -120, -111,  83,   28,  -88,  -55, -106,  -26,    4, -115,  -47,  -59,  -15,  161,   -4,
         -62,   98,   39,  65,   92,   14,   81,  -22, -151,  -17,  -21,  -74,   54,  115,  106,   98,
           0,  -98, -106, -115, -54,   74,   21,   17,  151,   22,  -81,  -14,  -92,  -65,  -39,  -98,
          62,    4, -161,  15,   59,   47,  115,   -4,   26,  106,   55,   88,  -28,  -83,  111,  120
    };

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [2:0]  ready_v;
    logic [2:0]  valid_v;
    logic [2:0]  last_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [15:0] i0, q0;
    logic [11:0] i1, q1;
    logic [19:0] i2, q2;
    logic [23:0] pi [3];
    logic [23:0] pq [3];

    int          vectors;
    int          miscompares;
    bit          exp_active [3];
    bit          exp_done   [3];
    bit          stall_prev [3];
    bit          abort_prev [3];
    int          idx        [3];
    logic [48:0] prev_obs   [3];

    preamble_seq_gen #(.DATA_W(16), .N_STS(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .m_valid(valid_v[0]), .m_ready(ready_v[0]), .m_i(i0), .m_q(q0),
        .m_last(last_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    preamble_seq_gen #(.DATA_W(12), .N_STS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .m_valid(valid_v[1]), .m_ready(ready_v[1]), .m_i(i1), .m_q(q1),
        .m_last(last_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    preamble_seq_gen #(.DATA_W(20), .N_STS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .m_valid(valid_v[2]), .m_ready(ready_v[2]), .m_i(i2), .m_q(q2),
        .m_last(last_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    always_comb begin
        pi[0] = {8'd0, i0};
        pq[0] = {8'd0, q0};
        pi[1] = {12'd0, i1};
        pq[1] = {12'd0, q1};
        pi[2] = {4'd0, i2};
        pq[2] = {4'd0, q2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lq(input int m);
        real r;
        r = real'(m) * 32.768;
        if (r >= 0.0) return $rtoi(r + 0.5);
        else return $rtoi(r - 0.5);
    endfunction

    function automatic logic [23:0] fit(input int v, input int dw);
        int e;
        logic [23:0] mask;
        if (dw >= 16) e = v <<< (dw - 16);
        else e = v >>> (16 - dw);
        mask = 24'((1 << dw) - 1);
        return 24'(e) & mask;
    endfunction

    // Expected {last, q, i} for sample k of a preamble with ns short symbols at width dw.
    function automatic logic [48:0] model(input int ns, input int dw, input int k);
        int v_i, v_q, a, base;
        base = ns * 16;
        if (k < base) begin
            a = k % 16;
            v_i = int'($signed(SH[a]));
            v_q = int'($signed(SH[(a + 8) % 16]));
        end else begin
            if (k < base + 32) a = 32 + k - base;
            else a = (k - base - 32) % 64;
            v_i = lq(LI[a]);
            v_q = lq(LQ[a]);
        end
`ifdef PREAMBLE_WINDOW_EN
        if ((k == 0) || (k == base)) begin
            v_i = v_i >>> 1;
            v_q = v_q >>> 1;
        end
`endif
        return {(k == base + 159), fit(v_q, dw), fit(v_i, dw)};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            exp_active[d] = 1'b0;
            exp_done[d]   = 1'b0;
            stall_prev[d] = 1'b0;
            abort_prev[d] = 1'b0;
            idx[d]        = 0;
        end
    endtask

    // Called at the falling edge after inputs for the next rising edge are applied.
    task automatic monitor();
        logic [48:0] obs;
        bit nxt_active, nxt_done;
        for (int d = 0; d < 3; d++) begin
            obs = {last_v[d], pq[d], pi[d]};
            check($sformatf("d%0d_valid", d), 64'(valid_v[d]), 64'(exp_active[d]));
            check($sformatf("d%0d_busy", d), 64'(busy_v[d]), 64'(exp_active[d]));
            check($sformatf("d%0d_done", d), 64'(done_v[d]), 64'(exp_done[d]));
            if (stall_prev[d]) check($sformatf("d%0d_hold", d), 64'(obs), 64'(prev_obs[d]));
            if (abort_prev[d]) check($sformatf("d%0d_abort_clr", d), 64'(obs), 64'd0);
            nxt_active    = exp_active[d];
            nxt_done      = 1'b0;
            stall_prev[d] = exp_active[d] && !ready_v[d] && !abort_v[d];
            abort_prev[d] = abort_v[d];
            prev_obs[d]   = obs;
            if (abort_v[d]) begin
                nxt_active = 1'b0;
            end else if (!exp_active[d]) begin
                if (start_v[d] && !exp_done[d]) begin
                    nxt_active = 1'b1;
                    idx[d]     = 0;
                end
            end else if (ready_v[d]) begin
                check($sformatf("d%0d_smp%0d", d, idx[d]), 64'(obs), 64'(model(NS[d], DW[d], idx[d])));
                if (idx[d] == NS[d] * 16 + 159) begin
                    nxt_active = 1'b0;
                    nxt_done   = 1'b1;
                end
                idx[d]++;
            end
            exp_active[d] = nxt_active;
            exp_done[d]   = nxt_done;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start_v = 3'b000;
            abort_v = 3'b000;
            ready_v = 3'($urandom);
            monitor();
        end
    endtask

    // Start all three streams and run until every one has finished (or abort_at hits dut0).
    task automatic run_phase(input int pct, input bit rand_start, input int abort_at);
        bit aborted;
        bit finished;
        aborted = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                ready_v[d] = ($urandom_range(99) < pct);
                if (c == 0) start_v[d] = 1'b1;
                else start_v[d] = rand_start && (exp_active[d] || exp_done[d]) && ($urandom_range(7) == 0);
                abort_v[d] = 1'b0;
            end
            if (abort_at >= 0 && !aborted && exp_active[0] && idx[0] == abort_at) begin
                abort_v[0] = 1'b1;
                aborted = 1'b1;
            end
            monitor();
            if (c > 0 && !exp_active[0] && !exp_done[0] && !exp_active[1] && !exp_done[1]
                && !exp_active[2] && !exp_done[2]) begin
                finished = 1'b1;
                break;
            end
        end
        check("phase_timeout", 64'(finished), 64'd1);
        for (int d = 0; d < 3; d++) begin
            if (!(aborted && d == 0)) check($sformatf("d%0d_len", d), 64'(idx[d]), 64'(NS[d] * 16 + 160));
        end
        if (abort_at >= 0) check("abort_idx", 64'(idx[0]), 64'(abort_at));
        idle_cycles(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_ctl%0d", tag, d), 64'({valid_v[d], busy_v[d], done_v[d], last_v[d]}), 64'd0);
            check($sformatf("%s_data%0d", tag, d), 64'({pq[d], pi[d]}), 64'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start_v = 3'b000;
        abort_v = 3'b000;
        ready_v = 3'b000;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle_cycles(5);

        run_phase(100, 1'b0, -1);
        run_phase(50, 1'b1, -1);
        run_phase(70, 1'b0, 200);
        run_phase(100, 1'b0, -1);

        // Asynchronous reset in the middle of the short training field.
        @(negedge clk);
        start_v = 3'b111;
        ready_v = 3'b111;
        monitor();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start_v = 3'b000;
            ready_v = 3'b111;
            monitor();
        end
        check("mid_run_busy", 64'(busy_v[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(6);
        run_phase(60, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
